// File: rtl/ahb_pkg.sv
// AHB-Lite encodings and refill sequencer state shared by the I-cache refill path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ahb_pkg;

   // AHB HTRANS encodings. BUSY is listed for completeness; the refill master never drives it.
   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } trans_types_e;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;

   // Refill sequencer states.
   //   RF_ADDR  : NONSEQ address phase of beat 0, no data phase yet
   //   RF_BURST : SEQ address phases overlapping the previous beat's data phase
   //   RF_DRAIN : final outstanding data phase (last beat, or the beat that took an ERROR)
   //   RF_DONE  : line_valid cycle; behaves like IDLE for new requests
   typedef enum logic [2:0] {
      RF_IDLE,
      RF_ADDR,
      RF_BURST,
      RF_DRAIN,
      RF_DONE
   } refill_state_e;

endpackage

// File: rtl/wrap_addr_gen.sv
// Wrapping-burst address/word-index generator for one cache line.
// Latency: combinational.
// Backpressure: none; the caller only advances 'beat' when the bus accepts.
// Ports: line_base (line-aligned address bits), w0 (critical word index), beat (beat number)
//        -> addr (byte address of that beat), word_idx (line word the beat belongs to).
module wrap_addr_gen #(
   parameter  int ADDR_W = 32,
   parameter  int BEATS  = 4,
   localparam int IDX_W  = $clog2(BEATS),
   localparam int BASE_W = ADDR_W - IDX_W - 2
) (
   input  logic [BASE_W-1:0] line_base,
   input  logic [IDX_W-1:0]  w0,
   input  logic [IDX_W-1:0]  beat,
   output logic [ADDR_W-1:0] addr,
   output logic [IDX_W-1:0]  word_idx
);

   // The sum truncates to IDX_W bits, which is exactly the wrap within the line.
   assign word_idx = w0 + beat;
   assign addr     = {line_base, word_idx, 2'b00};

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache refill master: one WRAP4 read burst per miss, critical word first, line presented with a valid pulse.
// Latency: zero-wait miss_req sampled at edge 0 -> NONSEQ cycle 1 -> line_valid cycle 6; +1 cycle per hready=0.
// Backpressure: hready=0 holds haddr/htrans/hburst and the data capture; miss_req outside IDLE/DONE is ignored.
// Ports: miss_req/miss_addr/miss_ack (request side), line_valid/line_addr/line_data/line_err (cache side),
//        crit_valid/crit_data (critical word forward), haddr/htrans/hwrite/hburst/hsize/hrdata/hready/hresp (AHB).
// Optional feature macro: CRIT_WORD_FWD_EN enables critical-word forwarding; otherwise crit_* tie to 0.
module icache_refill_ctrl
   import ahb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int BEATS  = 4
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    miss_req,
   input  logic [ADDR_W-1:0]       miss_addr,
   output logic                    miss_ack,
   output logic                    line_valid,
   output logic [ADDR_W-1:0]       line_addr,
   output logic [BEATS*DATA_W-1:0] line_data,
   output logic                    line_err,
   output logic                    crit_valid,
   output logic [DATA_W-1:0]       crit_data,
   output logic [ADDR_W-1:0]       haddr,
   output logic [1:0]              htrans,
   output logic                    hwrite,
   output logic [2:0]              hburst,
   output logic [2:0]              hsize,
   input  logic [DATA_W-1:0]       hrdata,
   input  logic                    hready,
   input  logic                    hresp
);

   localparam int IDX_W  = $clog2(BEATS);
   localparam int BASE_W = ADDR_W - IDX_W - 2;
   localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);
   localparam logic [IDX_W-1:0] ONE_BEAT  = IDX_W'(1);

   refill_state_e           state_q, state_d;
   logic [IDX_W-1:0]        a_cnt_q, a_cnt_d;     // beat whose address phase is on the bus
   logic                    abort_q, abort_d;     // ERROR seen, waiting for its second cycle
   logic [BASE_W-1:0]       base_q, base_d;
   logic [IDX_W-1:0]        w0_q, w0_d;
   logic [ADDR_W-1:0]       haddr_q, haddr_d;
   trans_types_e            htrans_q, htrans_d;
   logic [2:0]              hburst_q, hburst_d;
   logic                    miss_ack_q, miss_ack_d;
   logic                    line_valid_q, line_valid_d;
   logic                    line_err_q, line_err_d;
   logic [ADDR_W-1:0]       line_addr_q, line_addr_d;
   logic [BEATS*DATA_W-1:0] line_data_q, line_data_d;

   logic                    cap_vld;              // a data beat completes this cycle
   logic [IDX_W-1:0]        a_nxt;
   logic [IDX_W-1:0]        d_beat;
   logic [ADDR_W-1:0]       nxt_addr;
   logic [IDX_W-1:0]        d_widx;
   logic [ADDR_W-1:0]       unused_daddr;
   logic [IDX_W-1:0]        unused_aidx;
   logic                    unused_lsb;

   assign unused_lsb = ^miss_addr[1:0];

   assign a_nxt = a_cnt_q + ONE_BEAT;
   // Data phase trails the address phase by one beat; in DRAIN only the last beat remains.
   assign d_beat = (state_q == RF_DRAIN) ? LAST_BEAT : (a_cnt_q - ONE_BEAT);

   wrap_addr_gen #(.ADDR_W(ADDR_W), .BEATS(BEATS)) u_addr_gen (
      .line_base (base_q),
      .w0        (w0_q),
      .beat      (a_nxt),
      .addr      (nxt_addr),
      .word_idx  (unused_aidx)
   );

   wrap_addr_gen #(.ADDR_W(ADDR_W), .BEATS(BEATS)) u_data_gen (
      .line_base (base_q),
      .w0        (w0_q),
      .beat      (d_beat),
      .addr      (unused_daddr),
      .word_idx  (d_widx)
   );

   always_comb begin
      state_d      = state_q;
      a_cnt_d      = a_cnt_q;
      abort_d      = abort_q;
      base_d       = base_q;
      w0_d         = w0_q;
      haddr_d      = haddr_q;
      htrans_d     = htrans_q;
      hburst_d     = hburst_q;
      line_addr_d  = line_addr_q;
      line_data_d  = line_data_q;
      miss_ack_d   = 1'b0;
      line_valid_d = 1'b0;
      line_err_d   = 1'b0;
      cap_vld      = 1'b0;

      case (state_q)
         RF_IDLE, RF_DONE: begin
            if (miss_req) begin
               state_d    = RF_ADDR;
               miss_ack_d = 1'b1;
               htrans_d   = HTRANS_NONSEQ;
               hburst_d   = HBURST_WRAP4;
               haddr_d    = {miss_addr[ADDR_W-1:2], 2'b00};
               base_d     = miss_addr[ADDR_W-1 -: BASE_W];
               w0_d       = miss_addr[2 +: IDX_W];
               a_cnt_d    = '0;
               abort_d    = 1'b0;
            end else begin
               state_d = RF_IDLE;
            end
         end

         RF_ADDR: begin
            // No data phase is outstanding yet, so only hready matters here.
            if (hready) begin
               state_d  = RF_BURST;
               a_cnt_d  = a_nxt;
               htrans_d = HTRANS_SEQ;
               haddr_d  = nxt_addr;
            end
         end

         RF_BURST: begin
            if (hresp && !hready) begin
               // First ERROR cycle: withdraw the pending SEQ so no further beats start.
               state_d  = RF_DRAIN;
               abort_d  = 1'b1;
               htrans_d = HTRANS_IDLE;
               hburst_d = HBURST_SINGLE;
            end else if (hready) begin
               cap_vld = 1'b1;
               if (a_cnt_q == LAST_BEAT) begin
                  state_d  = RF_DRAIN;
                  htrans_d = HTRANS_IDLE;
                  hburst_d = HBURST_SINGLE;
               end else begin
                  a_cnt_d = a_nxt;
                  haddr_d = nxt_addr;
               end
            end
         end

         RF_DRAIN: begin
            if (abort_q) begin
               if (hready) begin
                  state_d    = RF_IDLE;
                  line_err_d = 1'b1;
                  abort_d    = 1'b0;
               end
            end else if (hresp && !hready) begin
               abort_d = 1'b1;
            end else if (hready) begin
               cap_vld      = 1'b1;
               state_d      = RF_DONE;
               line_valid_d = 1'b1;
               line_addr_d  = {base_q, {(IDX_W + 2){1'b0}}};
            end
         end

         default: state_d = RF_IDLE;
      endcase

      if (cap_vld) begin
         line_data_d[d_widx*DATA_W +: DATA_W] = hrdata;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= RF_IDLE;
         a_cnt_q      <= '0;
         abort_q      <= 1'b0;
         base_q       <= '0;
         w0_q         <= '0;
         haddr_q      <= '0;
         htrans_q     <= HTRANS_IDLE;
         hburst_q     <= HBURST_SINGLE;
         miss_ack_q   <= 1'b0;
         line_valid_q <= 1'b0;
         line_err_q   <= 1'b0;
         line_addr_q  <= '0;
         line_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         a_cnt_q      <= a_cnt_d;
         abort_q      <= abort_d;
         base_q       <= base_d;
         w0_q         <= w0_d;
         haddr_q      <= haddr_d;
         htrans_q     <= htrans_d;
         hburst_q     <= hburst_d;
         miss_ack_q   <= miss_ack_d;
         line_valid_q <= line_valid_d;
         line_err_q   <= line_err_d;
         line_addr_q  <= line_addr_d;
         line_data_q  <= line_data_d;
      end
   end

`ifdef CRIT_WORD_FWD_EN
   logic              crit_valid_q, crit_valid_d;
   logic [DATA_W-1:0] crit_data_q, crit_data_d;

   // Beat 0 is always the critical word; an ERROR on it never sets cap_vld.
   always_comb begin
      crit_valid_d = cap_vld && (d_beat == '0);
      crit_data_d  = crit_valid_d ? hrdata : crit_data_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         crit_valid_q <= 1'b0;
         crit_data_q  <= '0;
      end else begin
         crit_valid_q <= crit_valid_d;
         crit_data_q  <= crit_data_d;
      end
   end

   assign crit_valid = crit_valid_q;
   assign crit_data  = crit_data_q;
`else
   assign crit_valid = 1'b0;
   assign crit_data  = '0;
`endif

   assign miss_ack   = miss_ack_q;
   assign line_valid = line_valid_q;
   assign line_err   = line_err_q;
   assign line_addr  = line_addr_q;
   assign line_data  = line_data_q;
   assign haddr      = haddr_q;
   assign htrans     = htrans_q;
   assign hburst     = hburst_q;
   assign hsize      = HSIZE_WORD;
   assign hwrite     = 1'b0;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: acts as the AHB slave and as the requester.
// Expected line contents come from an address-to-data function (word i of a line holds the data of address base+4*i),
// expected beat order from wrap arithmetic, expected latency from 6 + counted wait cycles.
module tb_icache_refill_ctrl;

   logic         clk;
   logic         rstn;
   logic         miss_req;
   logic [31:0]  miss_addr;
   logic         miss_ack;
   logic         line_valid;
   logic [31:0]  line_addr;
   logic [127:0] line_data;
   logic         line_err;
   logic         crit_valid;
   logic [31:0]  crit_data;
   logic [31:0]  haddr;
   logic [1:0]   htrans;
   logic         hwrite;
   logic [2:0]   hburst;
   logic [2:0]   hsize;
   logic [31:0]  hrdata;
   logic         hready;
   logic         hresp;

   int           checks;
   int           errors;
   logic [31:0]  seed;

   icache_refill_ctrl #(.ADDR_W(32), .DATA_W(32), .BEATS(4)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .miss_req   (miss_req),
      .miss_addr  (miss_addr),
      .miss_ack   (miss_ack),
      .line_valid (line_valid),
      .line_addr  (line_addr),
      .line_data  (line_data),
      .line_err   (line_err),
      .crit_valid (crit_valid),
      .crit_data  (crit_data),
      .haddr      (haddr),
      .htrans     (htrans),
      .hwrite     (hwrite),
      .hburst     (hburst),
      .hsize      (hsize),
      .hrdata     (hrdata),
      .hready     (hready),
      .hresp      (hresp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Slave memory image: data returned for a word address.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ seed;
   endfunction

   task automatic idle(input int n);
      miss_req = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         check("idle_htrans", 32'(htrans), 32'd0);
         check("idle_line_valid", 32'(line_valid), 32'd0);
         check("idle_miss_ack", 32'(miss_ack), 32'd0);
      end
   endtask

   // One refill. Starts in the current cycle (cycle 0: request driven) and returns in the
   // line_valid or line_err cycle without advancing time, so a following call is back-to-back.
   task automatic refill(input logic [31:0] addr, input int wait_pct, input int stall_beat,
                         input int stall_len, input int err_beat, input bit spur);
      logic [31:0] base, paddr, p_haddr;
      logic [31:0] exp_a[4];
      logic [1:0]  p_trans;
      logic        p_rdy, pend, got0, done, fin, completed;
      int          cyc, n_a, n_d, waits, stall_left, errph, w0;

      seed = $urandom;
      base = {addr[31:4], 4'h0};
      w0   = int'(addr[3:2]);
      for (int k = 0; k < 4; k++) exp_a[k] = base + 32'(((w0 + k) % 4) * 4);

      miss_req = 1'b1; miss_addr = addr;
      hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
      p_trans = htrans; p_haddr = haddr; p_rdy = 1'b1; pend = 1'b0; paddr = '0;
      cyc = 0; n_a = 0; n_d = 0; waits = 0; stall_left = stall_len; errph = 0;
      fin = 1'b0; completed = 1'b0;

      while (!fin) begin
         @(posedge clk); #1;
         cyc++;
         got0 = 1'b0; done = 1'b0;
         if (errph == 2) begin
            check("err_line_err", 32'(line_err), 32'd1);
            check("err_no_line_valid", 32'(line_valid), 32'd0);
            fin = 1'b1; completed = 1'b1;
         end else begin
            if (p_rdy) begin
               if (pend) begin
                  n_d++; pend = 1'b0;
                  got0 = (n_d == 1); done = (n_d == 4);
               end
               if (p_trans != 2'b00) begin
                  check("beat_in_range", 32'(n_a < 4), 32'd1);
                  if (n_a < 4) begin
                     check("beat_haddr", p_haddr, exp_a[n_a]);
                     check("beat_htrans", 32'(p_trans), (n_a == 0) ? 32'd2 : 32'd3);
                  end
                  pend = 1'b1; paddr = p_haddr; n_a++;
               end
            end
            if (errph == 1) begin
               check("err_htrans_idle", 32'(htrans), 32'd0);
            end else if (!p_rdy) begin
               check("stall_haddr_hold", haddr, p_haddr);
               check("stall_htrans_hold", 32'(htrans), 32'(p_trans));
            end
            if (htrans != 2'b00) check("hburst_wrap4", 32'(hburst), 32'd2);
            check("miss_ack", 32'(miss_ack), 32'(cyc == 1));
            check("line_valid", 32'(line_valid), 32'(done));
            check("line_err_quiet", 32'(line_err), 32'd0);
`ifdef CRIT_WORD_FWD_EN
            check("crit_valid", 32'(crit_valid), 32'(got0));
            if (got0) check("crit_data", crit_data, mem(exp_a[0]));
`else
            check("crit_valid_off", 32'(crit_valid), 32'd0);
            check("crit_data_off", crit_data, 32'd0);
`endif
            if (done) begin
               check("latency", 32'(cyc), 32'(6 + waits));
               check("line_addr", line_addr, base);
               for (int i = 0; i < 4; i++)
                  check("line_word", line_data[i*32 +: 32], mem(base + 32'(4 * i)));
               fin = 1'b1; completed = 1'b1;
            end
         end
         if (cyc >= 80) fin = 1'b1;
         if (!fin) begin
            miss_req = spur;
            if (spur) miss_addr = $urandom;
            hresp = 1'b0; hready = 1'b1; hrdata = $urandom;
            if (pend) begin
               hrdata = mem(paddr);
               if (errph == 1) begin
                  hresp = 1'b1; hready = 1'b1; errph = 2;
               end else if (n_d == err_beat) begin
                  hresp = 1'b1; hready = 1'b0; errph = 1;
               end else if (n_d == stall_beat && stall_left > 0) begin
                  hready = 1'b0; stall_left--; waits++;
               end else if ($urandom_range(0, 99) < wait_pct) begin
                  hready = 1'b0; waits++;
               end
            end
            p_trans = htrans; p_haddr = haddr; p_rdy = hready;
         end
      end
      check("refill_completed", 32'(completed), 32'd1);
      miss_req = 1'b0; hready = 1'b1; hresp = 1'b0;
   endtask

   initial begin
      int eb;
      checks = 0; errors = 0; seed = '0;
      miss_req = 1'b0; miss_addr = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
      rstn = 1'b1;
      #2 rstn = 1'b0;
      #2;
      check("rst_htrans", 32'(htrans), 32'd0);
      check("rst_haddr", haddr, 32'd0);
      check("rst_hburst", 32'(hburst), 32'd0);
      check("rst_hsize", 32'(hsize), 32'd2);
      check("rst_hwrite", 32'(hwrite), 32'd0);
      check("rst_miss_ack", 32'(miss_ack), 32'd0);
      check("rst_line_valid", 32'(line_valid), 32'd0);
      check("rst_line_err", 32'(line_err), 32'd0);
      check("rst_line_addr", line_addr, 32'd0);
      check("rst_crit_valid", 32'(crit_valid), 32'd0);
      check("rst_crit_data", crit_data, 32'd0);
      check("rst_line_data_w0", line_data[31:0], 32'd0);
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;

      // Zero-wait refill, critical word in the middle of the line.
      refill(32'h0000_1008, 0, -1, 0, -1, 1'b0);
      idle(2);
      // Two-cycle stall during beat 1 data phase.
      refill(32'h0000_4004, 0, 1, 2, -1, 1'b0);
      idle(1);
      // ERROR on beat 2, then a normal refill.
      refill(32'h0000_5000, 0, -1, 0, 2, 1'b0);
      idle(1);
      refill(32'h0000_600C, 0, -1, 0, -1, 1'b0);
      // ERROR on beat 0: no critical-word pulse.
      refill(32'h0000_7004, 0, -1, 0, 0, 1'b0);
      idle(1);

      // Reset in the middle of a burst.
      miss_req = 1'b1; miss_addr = 32'h3000_0014; hready = 1'b1; hrdata = $urandom;
      @(posedge clk); #1;
      miss_req = 1'b0;
      repeat (2) begin @(posedge clk); #1; hrdata = $urandom; end
      rstn = 1'b0;
      #1;
      check("midrst_htrans", 32'(htrans), 32'd0);
      check("midrst_haddr", haddr, 32'd0);
      check("midrst_hburst", 32'(hburst), 32'd0);
      check("midrst_miss_ack", 32'(miss_ack), 32'd0);
      check("midrst_line_valid", 32'(line_valid), 32'd0);
      check("midrst_crit_valid", 32'(crit_valid), 32'd0);
      check("midrst_line_data", line_data[127:96] | line_data[95:64] | line_data[63:32] | line_data[31:0], 32'd0);
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
      idle(1);
      refill(32'h3000_0018, 0, -1, 0, -1, 1'b0);

      // Back-to-back: request held high throughout, second miss accepted in the line_valid cycle.
      refill(32'h0000_8008, 0, -1, 0, -1, 1'b1);
      refill(32'h2000_0000, 0, -1, 0, -1, 1'b0);
      idle(1);

      // Randomized refills with wait states, occasional errors and spurious requests.
      for (int t = 0; t < 30; t++) begin
         eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
         refill($urandom, 30, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), eb,
                1'($urandom_range(0, 1)));
         idle(int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

AHB master-side refill sequencer for the I-cache: on a cache miss it issues one WRAP4 read burst, critical word first, and drives the AHB address/control signals that the transfer handler carries. Returned beats are placed into a line buffer at their wrapped word positions, and the full line is presented to the cache with a one-cycle valid pulse. It is the only AHB master on the instruction side, and it owns all burst sequencing, stall handling and error abort.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data/word width
- BEATS, 4, words per line (fixed WRAP4; other values unsupported)

- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- miss_req  in  1  refill request, level, held until miss_ack
- miss_addr  in  ADDR_W  missing instruction address
- miss_ack  out  1  one-cycle pulse: request accepted
- line_valid  out  1  one-cycle pulse: line_data/line_addr valid
- line_addr  out  ADDR_W  line-aligned base (low log2(BEATS)+2 bits zero)
- line_data  out  BEATS*DATA_W  word i at bits [i*DATA_W +: DATA_W]
- line_err  out  1  one-cycle pulse: burst aborted by ERROR response
- crit_valid  out  1  critical-word pulse (CRIT_WORD_FWD_EN)
- crit_data  out  DATA_W  critical word
- haddr  out  ADDR_W  AHB address
- htrans  out  2  AHB transfer type (IDLE/NONSEQ/SEQ only; BUSY never driven)
- hwrite  out  1  constant 0
- hburst  out  3  3'b010 (WRAP4) during a burst, else 0
- hsize  out  3  3'b010 (word)
- hrdata  in  DATA_W  AHB read data
- hready  in  1  AHB ready
- hresp  in  1  AHB response, 1 = ERROR

## Operation
- States: IDLE, ADDR (NONSEQ beat 0), BURST (SEQ addresses plus overlapping data phases), DRAIN (last data phase only), DONE.
- IDLE: miss_req=1 is sampled and captured. Next cycle: state ADDR, miss_ack=1, htrans=NONSEQ, haddr={miss_addr[31:2],2'b00}.
- Beat k address = {line base, (w0+k) mod BEATS, 2'b00}, where w0=miss_addr[3:2]; the address wraps within the 16-byte line.
- Address counter advances only on cycles with hready=1. While hready=0, haddr/htrans/hburst are held unchanged.
- A data beat is captured when hready=1 and the beat is in its data phase. Beat k is written to line word (w0+k) mod BEATS.
- After the 4th address is accepted, htrans=IDLE (DRAIN). After the 4th data beat is captured, state DONE: line_valid=1 for one cycle, then IDLE.
- ERROR (hresp=1, hready=0, first cycle): drive htrans=IDLE next cycle and cancel remaining beats. line_err pulses once the second ERROR cycle completes; line_valid is not asserted; return to IDLE. line_data is then undefined.
- miss_req while not IDLE is ignored, with no queueing.

## Timing
- Reset values: miss_ack, line_valid, line_err, crit_valid = 0; htrans=IDLE; haddr, line_addr, line_data, crit_data, hburst = 0; hsize=3'b010; hwrite=0; state IDLE.
- Zero-wait latency: miss_req sampled at edge 0 → NONSEQ in cycle 1 → data beats sampled at edges ending cycles 2–5 → line_valid in cycle 6.
- Each hready=0 cycle adds exactly one cycle of latency.
- line_data/line_addr remain stable from line_valid until the next miss_ack.
- line_valid cycle is IDLE: a miss_req present then is accepted, giving NONSEQ in cycle 7.
- Reset mid-burst: all outputs take their reset values asynchronously, htrans=IDLE immediately, and any pending slave data is discarded.

## Configuration
- CRIT_WORD_FWD_EN defined: crit_valid pulses the cycle after beat 0 is captured (cycle 3 at zero wait), with crit_data = beat 0. No pulse on an ERROR during beat 0.
- CRIT_WORD_FWD_EN undefined: ports still exist; crit_valid=0 and crit_data=0 permanently, and no forwarding logic is synthesized.

## Structure
- Shared package ahb_pkg holds:
  - TRANS_TYPES enum (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11)
  - HBURST_WRAP4=3'b010, HSIZE_WORD=3'b010
  - refill state enum
- One sub-module: wrap_addr_gen. Combinational; takes line base, w0 and beat count, and returns haddr and line word index. Shared by the address and data counters.

## Test plan
- Zero-wait refill of miss_addr=32'h0000_1008: haddr sequence 1008,100C,1000,1004 with NONSEQ,SEQ,SEQ,SEQ; hrdata A,B,C,D → line_data words {C,D,A,B}, line_addr=32'h1000, line_valid in cycle 6.
- hready=0 for 2 cycles during the beat-1 data phase: haddr/htrans held, line_valid in cycle 8, data order unchanged.
- ERROR on beat 2 (two-cycle hresp): htrans=IDLE follows, line_err pulses once, no line_valid, next miss_req is accepted normally.
- Assert rstn=0 mid-burst: htrans=IDLE and all pulses 0 immediately; after release the controller is in IDLE and a new miss completes with correct data.
- Back-to-back: miss_req held high through line_valid → second NONSEQ in cycle 7; second miss_addr=32'h2000_0000 gives ascending order 0,4,8,C.
- With CRIT_WORD_FWD_EN: zero-wait miss → crit_valid in cycle 3 with crit_data=A. Without the macro, crit_valid stays 0.
